// File: rtl/adc2_burst_packer_if.sv
// Purpose : output stream of adc2_burst_packer, FIFO head towards the consumer.
// Latency : none (wires only).
// Backpressure: consumer drives out_ready; a pop is out_valid && out_ready.
//
// Ports (signals):
//   out_data  [2*DW-1:0]  FIFO head, {q2,q1}; don't care while out_valid=0
//   out_valid             FIFO non-empty
//   out_ready             consumer accepts the head this cycle
interface adc2_burst_packer_if #(
    parameter int DW = 16
);
    logic [2*DW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    // master = packer (source), slave = consumer (sink)
    modport master (output out_data, output out_valid, input  out_ready);
    modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/adc2_burst_packer.sv
// Purpose : packs DDR-captured ADC2 words {q2,q1} into 32-bit pairs, captures
//           BURST_LEN pairs per start into a FWFT FIFO, counts dropped pairs.
// Latency : pair offered in cycle N is written at the end of N and is on
//           out_data in cycle N+1 if the FIFO was empty.
// Backpressure: out_valid/out_ready; a full FIFO drops the pair (ovf/ovf_cnt)
//           unless a pop frees a slot in the same cycle.
//
// Ports:
//   Adc2DCO, Adc2Rst_n  capture clock and async active-low reset
//   q1, q2              rising/falling-edge ADC words
//   start, abort        one-cycle commands (abort wins)
//   out_if              FIFO head stream (master modport)
//   busy, done          state != IDLE; one-cycle end-of-burst pulse
//   ovf, ovf_cnt        sticky drop flag and saturating drop count
//   level               FIFO occupancy 0..DEPTH
module adc2_burst_packer #(
    parameter int DW        = 16,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int BURST_LEN = 256
) (
    input  logic                       Adc2DCO,
    input  logic                       Adc2Rst_n,
    input  logic [DW-1:0]              q1,
    input  logic [DW-1:0]              q2,
    input  logic                       start,
    input  logic                       abort,
    adc2_burst_packer_if.master        out_if,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf,
    output logic [7:0]                 ovf_cnt,
    output logic [AW:0]                level
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam logic [15:0]   LAST_SMP = 16'(BURST_LEN - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t          state_q, state_d;
    logic [15:0]     smp_cnt_q, smp_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      ovf_cnt_q, ovf_cnt_d;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [2*DW-1:0] mem_q [DEPTH];

    logic            offer;
    logic            pop;
    logic            push;
    logic            flush;
    logic            fifo_vld;

    // ------------------------------------------------------------------
    // FIFO handshake. Occupancy comes from a separate AW+1 bit count so a
    // full FIFO is never confused with an empty one when pointers meet.
    // ------------------------------------------------------------------
    assign fifo_vld = (count_q != '0);
    assign pop      = fifo_vld && out_if.out_ready;
    // An aborting cycle neither writes nor counts as a drop.
    assign offer    = (state_q == ST_CAPTURE) && !abort;
    // A full FIFO still accepts the pair when the head leaves this cycle.
    assign push     = offer && ((count_q != FULL_LVL) || pop);

    // ------------------------------------------------------------------
    // Control FSM: next state, sample counter, overflow bookkeeping.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        done_d    = 1'b0;
        flush     = 1'b0;

        if (abort) begin
            // ovf/ovf_cnt are kept so software can still read why it aborted
            state_d   = ST_IDLE;
            smp_cnt_d = '0;
            flush     = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_CAPTURE;
                        smp_cnt_d = '0;
                        ovf_d     = 1'b0;
                        ovf_cnt_d = '0;
                    end
                end
                ST_CAPTURE: begin
                    smp_cnt_d = smp_cnt_q + 16'd1;
                    if (smp_cnt_q == LAST_SMP) begin
                        state_d = ST_DRAIN;
                    end
                    if (!push) begin
                        ovf_d = 1'b1;
                        if (ovf_cnt_q != 8'hFF) begin
                            ovf_cnt_d = ovf_cnt_q + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // no writes happen in DRAIN, so empty means finished
                    if (count_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // FIFO pointer / occupancy next state.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + LVL_ONE;
                2'b01:   count_d = count_q - LVL_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Adc2DCO or negedge Adc2Rst_n) begin
        if (!Adc2Rst_n) begin
            state_q   <= ST_IDLE;
            smp_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge Adc2DCO) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {q2, q1};
        end
    end

    // Head is gated so every output reads 0 while empty or in reset.
    assign out_if.out_valid = fifo_vld;
    assign out_if.out_data  = fifo_vld ? mem_q[rd_ptr_q] : '0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign ovf_cnt = ovf_cnt_q;
    assign level   = count_q;

endmodule

// File: tb/tb_adc2_burst_packer.sv
// Purpose : self-checking bench for adc2_burst_packer (three burst lengths).
// Latency : checks FWFT head, burst completion and done pulse timing.
// Backpressure: drives out_ready per test to exercise full/drop/flush cases.
module tb_adc2_burst_packer;

    logic        clk;
    logic        rst_n;
    logic [15:0] q1, q2;
    logic        start   [3];
    logic        abort   [3];
    logic        rdy     [3];
    logic        vld     [3];
    logic [31:0] dat     [3];
    logic        busy    [3];
    logic        done    [3];
    logic        ovf     [3];
    logic [7:0]  ovf_cnt [3];
    logic [4:0]  level   [3];

    logic [31:0] exp_q [3][$];
    int          done_cnt [3];
    int          pop_cnt  [3];
    int          n_vec;
    int          n_err;

    typedef struct {
        logic [15:0] q1;
        logic [15:0] q2;
        logic [31:0] exp_pair;
    } vec_t;
    vec_t tbl [8];

    adc2_burst_packer_if #(.DW(16)) bus0 ();
    adc2_burst_packer_if #(.DW(16)) bus1 ();
    adc2_burst_packer_if #(.DW(16)) bus2 ();

    assign bus0.out_ready = rdy[0];
    assign bus1.out_ready = rdy[1];
    assign bus2.out_ready = rdy[2];
    assign vld[0] = bus0.out_valid;
    assign vld[1] = bus1.out_valid;
    assign vld[2] = bus2.out_valid;
    assign dat[0] = bus0.out_data;
    assign dat[1] = bus1.out_data;
    assign dat[2] = bus2.out_data;

    adc2_burst_packer #(.DW(16), .DEPTH(16), .AW(4), .BURST_LEN(8)) u_dut0 (
        .Adc2DCO(clk), .Adc2Rst_n(rst_n), .q1(q1), .q2(q2),
        .start(start[0]), .abort(abort[0]), .out_if(bus0.master),
        .busy(busy[0]), .done(done[0]), .ovf(ovf[0]),
        .ovf_cnt(ovf_cnt[0]), .level(level[0])
    );

    adc2_burst_packer #(.DW(16), .DEPTH(16), .AW(4), .BURST_LEN(20)) u_dut1 (
        .Adc2DCO(clk), .Adc2Rst_n(rst_n), .q1(q1), .q2(q2),
        .start(start[1]), .abort(abort[1]), .out_if(bus1.master),
        .busy(busy[1]), .done(done[1]), .ovf(ovf[1]),
        .ovf_cnt(ovf_cnt[1]), .level(level[1])
    );

    adc2_burst_packer #(.DW(16), .DEPTH(16), .AW(4), .BURST_LEN(256)) u_dut2 (
        .Adc2DCO(clk), .Adc2Rst_n(rst_n), .q1(q1), .q2(q2),
        .start(start[2]), .abort(abort[2]), .out_if(bus2.master),
        .busy(busy[2]), .done(done[2]), .ovf(ovf[2]),
        .ovf_cnt(ovf_cnt[2]), .level(level[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Sampled on the falling edge: count done pulses, score every pop.
    task automatic monitor();
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) done_cnt[i]++;
            if (vld[i] === 1'b1 && rdy[i] === 1'b1) begin
                pop_cnt[i]++;
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("unexpected_pop%0d", i), dat[i], 32'hxxxxxxxx);
                end else begin
                    e = exp_q[i].pop_front();
                    chk($sformatf("pop_data%0d", i), dat[i], e);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats(input int d);
        done_cnt[d] = 0;
        pop_cnt[d]  = 0;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        step();
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        for (int k = 0; k < budget && done_cnt[d] == 0; k++) step();
        chk($sformatf("done_seen%0d", d), 32'(done_cnt[d]), 32'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        q1 = '0;
        q2 = '0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; rdy[i] = 1'b0;
            clear_stats(i);
        end
        for (int i = 0; i < 8; i++) begin
            tbl[i].q1       = 16'h0001 + 16'(i);
            tbl[i].q2       = 16'h1001 + 16'(i);
            tbl[i].exp_pair = 32'h10010001 + 32'(i) * 32'h00010001;
        end

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy",  {31'd0, busy[i]}, 32'd0);
            chk("rst_done",  {31'd0, done[i]}, 32'd0);
            chk("rst_ovf",   {31'd0, ovf[i]},  32'd0);
            chk("rst_ovfc",  {24'd0, ovf_cnt[i]}, 32'd0);
            chk("rst_level", {27'd0, level[i]}, 32'd0);
            chk("rst_valid", {31'd0, vld[i]}, 32'd0);
        end
        rst_n = 1'b1;
        step();

        // ---------------- T1: BURST_LEN=8, ready always ----------------
        rdy[0] = 1'b1;
        clear_stats(0);
        pulse_start(0);
        for (int i = 0; i < 8; i++) begin
            q1 = tbl[i].q1; q2 = tbl[i].q2;
            exp_q[0].push_back(tbl[i].exp_pair);
            step();
        end
        q1 = 16'hDEAD; q2 = 16'hBEEF;
        wait_done(0, 20);
        repeat (4) step();
        chk("t1_pops",   32'(pop_cnt[0]), 32'd8);
        chk("t1_done1",  32'(done_cnt[0]), 32'd1);
        chk("t1_ovf",    {31'd0, ovf[0]}, 32'd0);
        chk("t1_busy",   {31'd0, busy[0]}, 32'd0);
        chk("t1_sb_empty", 32'(exp_q[0].size()), 32'd0);

        // ---------------- T2: BURST_LEN=20, stalled -> 4 drops ----------------
        rdy[1] = 1'b0;
        clear_stats(1);
        pulse_start(1);
        for (int i = 0; i < 20; i++) begin
            q1 = 16'h0100 + 16'(i); q2 = 16'h2100 + 16'(i);
            if (i < 16) exp_q[1].push_back({q2, q1});
            step();
        end
        chk("t2_level",  {27'd0, level[1]}, 32'd16);
        chk("t2_ovf",    {31'd0, ovf[1]}, 32'd1);
        chk("t2_ovfcnt", {24'd0, ovf_cnt[1]}, 32'd4);
        chk("t2_busy",   {31'd0, busy[1]}, 32'd1);
        chk("t2_head",   dat[1], 32'h21000100);
        repeat (2) step();
        chk("t2_head_stable", dat[1], 32'h21000100);
        rdy[1] = 1'b1;
        wait_done(1, 40);
        chk("t2_pops",   32'(pop_cnt[1]), 32'd16);
        chk("t2_ovf_sticky", {31'd0, ovf[1]}, 32'd1);
        chk("t2_busy_end", {31'd0, busy[1]}, 32'd0);

        // ---------------- T3: full FIFO with simultaneous push/pop ----------------
        rdy[1] = 1'b0;
        clear_stats(1);
        pulse_start(1);
        chk("t3_ovf_cleared",  {31'd0, ovf[1]}, 32'd0);
        chk("t3_ovfc_cleared", {24'd0, ovf_cnt[1]}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            q1 = 16'h0300 + 16'(i); q2 = 16'h4300 + 16'(i);
            exp_q[1].push_back({q2, q1});
            if (i == 16) rdy[1] = 1'b1;
            step();
            if (i >= 15) chk($sformatf("t3_level_%0d", i), {27'd0, level[1]}, 32'd16);
        end
        chk("t3_ovfcnt", {24'd0, ovf_cnt[1]}, 32'd0);
        wait_done(1, 40);
        chk("t3_pops", 32'(pop_cnt[1]), 32'd20);

        // ---------------- T4: abort 5 cycles into a 256 burst ----------------
        rdy[2] = 1'b0;
        clear_stats(2);
        pulse_start(2);
        for (int i = 0; i < 5; i++) begin
            q1 = 16'h0500 + 16'(i); q2 = 16'h6500 + 16'(i);
            step();
        end
        abort[2] = 1'b1;
        start[2] = 1'b1;
        step();
        abort[2] = 1'b0;
        start[2] = 1'b0;
        exp_q[2].delete();
        chk("t4_busy",  {31'd0, busy[2]}, 32'd0);
        chk("t4_level", {27'd0, level[2]}, 32'd0);
        chk("t4_valid", {31'd0, vld[2]}, 32'd0);
        rdy[2] = 1'b1;
        repeat (10) step();
        chk("t4_no_done", 32'(done_cnt[2]), 32'd0);
        clear_stats(2);
        pulse_start(2);
        for (int i = 0; i < 256; i++) begin
            q1 = 16'(i * 3); q2 = ~16'(i);
            exp_q[2].push_back({q2, q1});
            step();
        end
        wait_done(2, 40);
        chk("t4_pops", 32'(pop_cnt[2]), 32'd256);
        chk("t4_ovf",  {31'd0, ovf[2]}, 32'd0);

        // ---------------- T5: start re-pulsed in CAPTURE and DRAIN ----------------
        rdy[0] = 1'b1;
        clear_stats(0);
        pulse_start(0);
        for (int i = 0; i < 8; i++) begin
            q1 = 16'h0700 + 16'(i); q2 = 16'h8700 + 16'(i);
            exp_q[0].push_back({q2, q1});
            start[0] = (i == 3);
            step();
        end
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_done(0, 20);
        repeat (12) step();
        chk("t5_pops",  32'(pop_cnt[0]), 32'd8);
        chk("t5_done1", 32'(done_cnt[0]), 32'd1);
        chk("t5_busy",  {31'd0, busy[0]}, 32'd0);

        // ---------------- T6: async reset mid-capture at level 7 ----------------
        rdy[0] = 1'b0;
        clear_stats(0);
        pulse_start(0);
        for (int i = 0; i < 7; i++) begin
            q1 = 16'h0900 + 16'(i); q2 = 16'hA900 + 16'(i);
            step();
        end
        chk("t6_level7", {27'd0, level[0]}, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy",  {31'd0, busy[0]}, 32'd0);
        chk("t6_done",  {31'd0, done[0]}, 32'd0);
        chk("t6_ovf",   {31'd0, ovf[0]}, 32'd0);
        chk("t6_ovfc",  {24'd0, ovf_cnt[0]}, 32'd0);
        chk("t6_level", {27'd0, level[0]}, 32'd0);
        chk("t6_valid", {31'd0, vld[0]}, 32'd0);
        chk("t6_data",  dat[0], 32'd0);
        exp_q[0].delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) step();
        chk("t6_idle", {31'd0, busy[0]}, 32'd0);
        chk("t6_no_done", 32'(done_cnt[0]), 32'd0);
        rdy[0] = 1'b1;
        pulse_start(0);
        for (int i = 0; i < 8; i++) begin
            q1 = 16'h0B00 + 16'(i); q2 = 16'hCB00 + 16'(i);
            exp_q[0].push_back({q2, q1});
            step();
        end
        wait_done(0, 20);
        chk("t6_pops", 32'(pop_cnt[0]), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
